// File: rtl/dot_operand_feeder.sv
// Operand feeder: holds A/B operand vectors and streams them pairwise to a dot
// unit under ready/valid flow control, framing each job with start/done pulses.
module dot_operand_feeder #(
   parameter int  WIDTH      = 16,
   parameter int  MAX_LENGTH = 64,
   localparam int ADDR_W     = $clog2(MAX_LENGTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] length,
   input  logic              go,
   input  logic              dot_ready,
   input  logic              dot_done,
   output logic              start_out,
   output logic [WIDTH-1:0]  a_out,
   output logic [WIDTH-1:0]  b_out,
   output logic              pair_valid,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_mem_a [MAX_LENGTH];
   logic [WIDTH-1:0]  r_mem_b [MAX_LENGTH];
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_len;
   logic              r_start;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic              w_xfer;
   logic              w_last;

   assign w_xfer = r_valid & dot_ready;
   assign w_last = (r_idx == r_len - ADDR_W'(1));

   // Buffers carry no reset; they are only writable while no job is in flight.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && wr_en) begin
         if (wr_sel)
            r_mem_b[wr_addr] <= wr_data;
         else
            r_mem_a[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len   <= '0;
         r_start <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (go) begin
                  if (length == '0) begin
                     r_error <= 1'b1;
                  end else begin
                     r_len   <= length;
                     r_idx   <= '0;
                     r_start <= 1'b1;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (w_xfer) begin
                  r_idx <= r_idx + ADDR_W'(1);
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_state <= WAIT_DONE;
                  end
               end
            end
            WAIT_DONE: begin
               if (dot_done) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign a_out      = r_mem_a[r_idx];
   assign b_out      = r_mem_b[r_idx];
   assign start_out  = r_start;
   assign pair_valid = r_valid;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;

endmodule
